// File: rtl/feature_desc_checker.sv
// -----------------------------------------------------------------------------
// feature_desc_checker
//   Receives the 10-word build-feature descriptor frame over a valid/ready
//   stream. Each word is decoded against its slot's category (value >> 8 must
//   equal slot+1, with the special values 0 = UNKNOWN and 1 = SIMU also legal)
//   and compared with this build's expected value. The per-slot mismatch and
//   category masks, the frame-length error and the idle timeout are reported
//   as a verdict that is held until the next frame starts.
//
// Ports
//   clk           clock
//   s_rst         synchronous reset, active-high
//   in_data[31:0] descriptor word (signed int enum value)
//   in_vld        word valid
//   in_last       last word of frame, qualified by in_vld
//   in_rdy        word accepted when in_vld & in_rdy
//   res_done      1-cycle pulse, verdict available
//   res_vld       verdict valid, from res_done until next frame's first accept
//   res_pass      all masks clear and no length/timeout error
//   res_mism_mask bit k: slot k value differs from expected
//   res_cat_mask  bit k: slot k has wrong category
//   res_len_err   frame shorter or longer than 10 words
//   res_timeout   frame aborted by idle timeout
// -----------------------------------------------------------------------------
module feature_desc_checker #(
   parameter int EXP_INT_TYPE    = 256,
   parameter int EXP_ARITH_MULT  = 512,
   parameter int EXP_MOD_MULT    = 768,
   parameter int EXP_MOD_REDUCT  = 1024,
   parameter int EXP_NTT_ARCH    = 1280,
   parameter int EXP_MOD_NTT     = 1536,
   parameter int EXP_APPLICATION = 1,
   parameter int EXP_OPTIM       = 2048,
   parameter int EXP_MSPLIT      = 2304,
   parameter int EXP_TOP         = 2560,
   parameter int TIMEOUT_CYC     = 1024
) (
   input  logic        clk,
   input  logic        s_rst,
   input  logic [31:0] in_data,
   input  logic        in_vld,
   input  logic        in_last,
   output logic        in_rdy,
   output logic        res_done,
   output logic        res_vld,
   output logic        res_pass,
   output logic [9:0]  res_mism_mask,
   output logic [9:0]  res_cat_mask,
   output logic        res_len_err,
   output logic        res_timeout
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RECV  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(TIMEOUT_CYC - 1);

   logic [1:0]       state;
   logic [1:0]       nxt;
   logic [3:0]       slot;
   logic [3:0]       cur_slot;
   logic [CNT_W-1:0] idle_cnt;
   logic             accept;
   logic             check_en;
   logic             set_len;
   logic             set_to;
   logic             cur_mism;
   logic             cur_cat;
   logic [9:0]       hit;

   function automatic logic [31:0] exp_val(input logic [3:0] k);
      case (k)
         4'd0:    exp_val = 32'(EXP_INT_TYPE);
         4'd1:    exp_val = 32'(EXP_ARITH_MULT);
         4'd2:    exp_val = 32'(EXP_MOD_MULT);
         4'd3:    exp_val = 32'(EXP_MOD_REDUCT);
         4'd4:    exp_val = 32'(EXP_NTT_ARCH);
         4'd5:    exp_val = 32'(EXP_MOD_NTT);
         4'd6:    exp_val = 32'(EXP_APPLICATION);
         4'd7:    exp_val = 32'(EXP_OPTIM);
         4'd8:    exp_val = 32'(EXP_MSPLIT);
         4'd9:    exp_val = 32'(EXP_TOP);
         default: exp_val = '0;
      endcase
   endfunction

   assign accept   = in_vld & in_rdy;
   // The first word is taken in IDLE, where the slot counter still reads 0.
   assign cur_slot = (state == ST_IDLE) ? 4'd0 : slot;
   assign hit      = 10'd1 << cur_slot;
   assign check_en = accept & ((state == ST_IDLE) | (state == ST_RECV));

   always_comb begin
      cur_mism = (in_data != exp_val(cur_slot));
      // Negative values are illegal; 0 and 1 are category-free; 2..255 illegal.
      if (in_data[31])
         cur_cat = 1'b1;
      else if (|in_data[31:8])
         cur_cat = (in_data[31:8] != ({20'd0, cur_slot} + 24'd1));
      else
         cur_cat = (in_data[7:0] > 8'd1);
   end

   always_comb begin
      nxt     = state;
      set_len = 1'b0;
      set_to  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               nxt     = in_last ? ST_DONE : ST_RECV;
               set_len = in_last;
            end
         end
         ST_RECV: begin
            if (accept) begin
               if (slot == 4'd9) begin
                  nxt     = in_last ? ST_DONE : ST_DRAIN;
                  set_len = ~in_last;
               end else if (in_last) begin
                  nxt     = ST_DONE;
                  set_len = 1'b1;
               end
            end else if (!in_vld && idle_cnt == IDLE_LIM) begin
               nxt    = ST_DONE;
               set_to = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (accept) begin
               if (in_last) nxt = ST_DONE;
            end else if (!in_vld && idle_cnt == IDLE_LIM) begin
               nxt    = ST_DONE;
               set_to = 1'b1;
            end
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         state         <= ST_IDLE;
         slot          <= '0;
         idle_cnt      <= '0;
         in_rdy        <= 1'b0;
         res_done      <= 1'b0;
         res_vld       <= 1'b0;
         res_mism_mask <= '0;
         res_cat_mask  <= '0;
         res_len_err   <= 1'b0;
         res_timeout   <= 1'b0;
      end else begin
         state    <= nxt;
         // Registered from the next state so DONE has in_rdy low for its one cycle.
         in_rdy   <= (nxt != ST_DONE);
         res_done <= (nxt == ST_DONE);

         if ((state == ST_RECV || state == ST_DRAIN) && !in_vld && nxt != ST_DONE)
            idle_cnt <= idle_cnt + 1'b1;
         else
            idle_cnt <= '0;

         if (state == ST_IDLE && accept)
            slot <= 4'd1;
         else if (state == ST_RECV && accept)
            slot <= slot + 4'd1;
         else if (state == ST_DONE)
            slot <= '0;

         if (state == ST_IDLE && accept) begin
            res_mism_mask <= cur_mism ? hit : '0;
            res_cat_mask  <= cur_cat  ? hit : '0;
            res_len_err   <= set_len;
            res_timeout   <= 1'b0;
         end else begin
            if (check_en) begin
               if (cur_mism) res_mism_mask <= res_mism_mask | hit;
               if (cur_cat)  res_cat_mask  <= res_cat_mask  | hit;
            end
            if (set_len) res_len_err <= 1'b1;
            // A timeout overrides any length error already flagged while draining.
            if (set_to) begin
               res_timeout <= 1'b1;
               res_len_err <= 1'b0;
            end
         end

         if (nxt == ST_DONE)
            res_vld <= 1'b1;
         else if (state == ST_IDLE && accept)
            res_vld <= 1'b0;
      end
   end

   assign res_pass = res_vld & ~(|res_mism_mask) & ~(|res_cat_mask) & ~res_len_err & ~res_timeout;

endmodule
